// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage data-access engine between the EX/MEM register and the data
// memory bus. Turns decoded store/load control into one bus transaction,
// formats store byte enables and lane-replicated data, and extends returned
// load data. Holds the pipeline while an access is outstanding, and aborts an
// access that spends WAIT_LIMIT cycles in REQ+WAIT.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_write/mem_read  store / load present in MEM (write wins if both)
//   mem_store_type      00 SB, 01 SH, 10 SW, 11 no write
//   mem_load_type       000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, other = LW
//   addr, wdata         byte address and store data
//   stall               hold the pipeline (combinational IDLE term)
//   load_data           extended load result, valid with load_valid
//   load_valid          one-cycle pulse in DONE after a successful load
//   misaligned          one-cycle pulse after a rejected access
//   bus_error           one-cycle pulse in DONE after a timeout abort
//   dmem_*              data-memory request/response bus
module mem_access_unit #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  mem_store_type,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  // The counter only has to represent 0 .. WAIT_LIMIT-1.
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Byte enables for a store of the given type at the given byte offset.
  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] ofs);
    case (st)
      2'b00:   store_be = 4'b0001 << ofs;
      2'b01:   store_be = 4'b0011 << {ofs[1], 1'b0};
      2'b10:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Replicate the store data onto every lane it could occupy.
  function automatic logic [31:0] store_fmt(input logic [1:0] st, input logic [31:0] wd);
    case (st)
      2'b00:   store_fmt = {4{wd[7:0]}};
      2'b01:   store_fmt = {2{wd[15:0]}};
      default: store_fmt = wd;
    endcase
  endfunction

  // Select the addressed lane and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] lt, input logic [1:0] lane,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lane, 3'b000} +: 8];
    h = rd[{lane[1], 4'b0000} +: 16];
    case (lt)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b011:  load_extend = {24'h00_0000, b};
      3'b100:  load_extend = {16'h0000, h};
      default: load_extend = rd;
    endcase
  endfunction

  // Half accesses need an even address, word accesses a multiple of four.
  function automatic logic access_misaligned(input logic is_st, input logic [1:0] st,
                                             input logic [2:0] lt, input logic [1:0] ofs);
    logic half;
    logic word;
    if (is_st) begin
      half = (st == 2'b01);
      word = (st == 2'b10);
    end else begin
      half = (lt == 3'b001) || (lt == 3'b100);
      word = !((lt == 3'b000) || (lt == 3'b011) || half);
    end
    access_misaligned = (half && ofs[0]) || (word && (ofs != 2'b00));
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         lt_q, lt_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               load_valid_q, load_valid_d;
  logic               misaligned_q, misaligned_d;
  logic               bus_error_q, bus_error_d;

  logic               is_store_s;
  logic               is_load_s;
  logic               misalign_s;
  logic               good_start_s;
  logic               timeout_s;

  assign is_store_s   = mem_write && (mem_store_type != 2'b11);
  assign is_load_s    = !is_store_s && mem_read;
  assign misalign_s   = access_misaligned(is_store_s, mem_store_type, mem_load_type, addr[1:0]);
  assign good_start_s = (state_q == S_IDLE) && (is_store_s || is_load_s) && !misalign_s;
  // Last permitted REQ/WAIT cycle: no completion now means abort.
  assign timeout_s    = (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  // Stall is forced low while in reset so a held instruction cannot freeze the pipe.
  assign stall = rst_n && (good_start_s || (state_q == S_REQ) || (state_q == S_WAIT));

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    lt_d         = lt_q;
    lane_d       = lane_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_store_s || is_load_s) begin
          if (misalign_s) begin
            misaligned_d = 1'b1;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_store_s;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = is_store_s ? store_be(mem_store_type, addr[1:0]) : 4'b0000;
            wdata_d = is_store_s ? store_fmt(mem_store_type, wdata) : 32'h0000_0000;
            lt_d    = mem_load_type;
            lane_d  = addr[1:0];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A granted write is complete; a read still needs its data.
        if (dmem_gnt && we_q) begin
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (timeout_s) begin
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          load_data_d = 32'h0000_0000;
          state_d     = S_DONE;
        end else if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end else begin
          req_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid) begin
          load_data_d  = load_extend(lt_q, lane_q, dmem_rdata);
          load_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (timeout_s) begin
          bus_error_d = 1'b1;
          load_data_d = 32'h0000_0000;
          state_d     = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        // Instruction is still on the inputs this cycle; it must not restart.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0000_0000;
      lt_q         <= 3'b000;
      lane_q       <= 2'b00;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      lt_q         <= lt_d;
      lane_q       <= lane_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misaligned = misaligned_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit. The driver issues one access at a
// time, computes the expected bus request, stall length and result from the
// access rules, and queues them; an independent monitor compares whatever the
// DUT presents on the opposite clock edge.
module tb_mem_access_unit;

  localparam int L     = 4;
  localparam int NEVER = 99;
  localparam logic [2:0] K_LOAD = 3'b100;
  localparam logic [2:0] K_ERR  = 3'b010;
  localparam logic [2:0] K_MIS  = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [1:0]  mem_store_type = 2'b11;
  logic [2:0]  mem_load_type = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_error;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  res_t res_q[$];
  req_t req_q[$];
  int   stall_q[$];
  int   total = 0;
  int   bad = 0;

  mem_access_unit #(.WAIT_LIMIT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_store_type(mem_store_type), .mem_load_type(mem_load_type),
    .addr(addr), .wdata(wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_error(bus_error),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got an event, expected none", nm);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b0; mem_store_type = 2'b11; mem_load_type = 3'b000;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
  endtask

  // One access. g: REQ cycles before gnt; rv: WAIT cycles before rvalid.
  task automatic access(input logic w, input logic r, input logic [1:0] st, input logic [2:0] lt,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int g, input int rv, input logic noise);
    bit          is_st, is_ld, sgn, ok;
    int          size, d;
    logic [31:0] v;
    req_t        q;
    res_t        e;
    is_st = w && (st != 2'b11);
    is_ld = !is_st && r;
    if (is_st) size = (st == 2'b00) ? 1 : (st == 2'b01) ? 2 : 4;
    else       size = (lt == 3'd0 || lt == 3'd3) ? 1 : (lt == 3'd1 || lt == 3'd4) ? 2 : 4;
    sgn = (lt == 3'd0) || (lt == 3'd1);
    @(posedge clk); #1;
    mem_write = w; mem_read = r; mem_store_type = st; mem_load_type = lt;
    addr = a; wdata = wd; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    if (!is_st && !is_ld) return;
    if ((size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0)) begin
      e.kind = K_MIS; e.data = 32'h0;
      res_q.push_back(e);
      return;
    end
    q.addr = a & 32'hFFFF_FFFC;
    q.we   = is_st;
    if (is_st) begin
      q.be    = (size == 1) ? 4'(32'd1 << (a % 4)) : (size == 2) ? 4'(32'd3 << (a % 4)) : 4'hF;
      q.wdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    end else begin
      q.be    = 4'h0;
      q.wdata = 32'h0;
    end
    req_q.push_back(q);
    ok = is_st ? (g + 1 <= L) : (g + rv + 2 <= L);
    d  = !ok ? L + 1 : is_st ? g + 2 : g + rv + 3;
    stall_q.push_back(d);
    if (size == 1) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    if (!ok) begin
      e.kind = K_ERR; e.data = 32'h0; res_q.push_back(e);
    end else if (is_ld) begin
      e.kind = K_LOAD; e.data = v; res_q.push_back(e);
    end
    for (int c = 1; c <= d; c++) begin
      @(posedge clk); #1;
      dmem_gnt = (c == g + 1);
      if (is_ld && c == g + rv + 2) begin
        dmem_rvalid = 1'b1; dmem_rdata = rd;
      end else if (is_ld && noise && c == g + 1) begin
        dmem_rvalid = 1'b1; dmem_rdata = ~rd;
      end else begin
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    int   run;
    bit   req_open;
    res_t e;
    req_t q;
    run = 0;
    req_open = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        req_open = 1'b0;
      end else begin
        if (load_valid || bus_error || misaligned) begin
          if (res_q.size() == 0) begin
            flag("unexpected_result");
          end else begin
            e = res_q.pop_front();
            chk("result_kind", {29'd0, load_valid, bus_error, misaligned}, {29'd0, e.kind});
            if (e.kind != K_MIS) chk("load_data", load_data, e.data);
          end
        end
        if (dmem_req) begin
          if (req_q.size() == 0) begin
            flag("unexpected_req");
          end else begin
            q = req_q[0];
            chk("dmem_addr", dmem_addr, q.addr);
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, q.be});
            chk("dmem_wdata", dmem_wdata, q.wdata);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, q.we});
            if (dmem_gnt) begin
              void'(req_q.pop_front());
              req_open = 1'b0;
            end else begin
              req_open = 1'b1;
            end
          end
        end else if (req_open) begin
          void'(req_q.pop_front());
          req_open = 1'b0;
        end
        if (stall) begin
          run++;
        end else if (run > 0) begin
          if (stall_q.size() == 0) flag("unexpected_stall");
          else chk("stall_len", run, stall_q.pop_front());
          run = 0;
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_pulses"}, {29'd0, load_valid, misaligned, bus_error}, 32'd0);
    chk({tag, "_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_dmem_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    chk({tag, "_dmem_be"}, {28'd0, dmem_be}, 32'd0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle_cycle();

    // Directed cases.
    access(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 1'b0);
    access(1'b0, 1'b1, 2'b11, 3'b000, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 0, 1'b0);
    access(1'b0, 1'b1, 2'b11, 3'b011, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 0, 1'b0);
    access(1'b0, 1'b1, 2'b11, 3'b100, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, 1'b0);
    access(1'b0, 1'b1, 2'b11, 3'b010, 32'h0000_2001, 32'h0, 32'h0, 0, 0, 1'b0);
    idle_cycle();
    access(1'b1, 1'b0, 2'b01, 3'b000, 32'h0000_3002, 32'h1234_BEEF, 32'h0, 3, 0, 1'b0);
    access(1'b0, 1'b1, 2'b11, 3'b010, 32'h0000_2004, 32'h0, 32'h5555_AAAA, 0, NEVER, 1'b1);
    access(1'b1, 1'b0, 2'b10, 3'b000, 32'h0000_4008, 32'hCAFE_F00D, 32'h0, NEVER, 0, 1'b0);
    access(1'b1, 1'b1, 2'b00, 3'b010, 32'h0000_5001, 32'h0000_0077, 32'h0, 1, 0, 1'b0);
    access(1'b1, 1'b0, 2'b11, 3'b000, 32'h0000_6000, 32'h0, 32'h0, 0, 0, 1'b0);
    idle_cycle();

    // Reset while a load sits in WAIT.
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b1; mem_load_type = 3'b010; addr = 32'h0000_0040;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    begin
      req_t q;
      q.addr = 32'h0000_0040; q.be = 4'h0; q.wdata = 32'h0; q.we = 1'b0;
      req_q.push_back(q);
    end
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst_n = 1'b0;
    res_q.delete(); req_q.delete(); stall_q.delete();
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    mem_read = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    access(1'b0, 1'b1, 2'b11, 3'b000, 32'h0000_0041, 32'h0, 32'h0000_F100, 1, 1, 1'b0);
    idle_cycle();

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      int          kind, g, rv;
      logic [1:0]  st;
      logic [2:0]  lt;
      logic        w, r;
      kind = $urandom_range(0, 9);
      lt   = 3'($urandom_range(0, 7));
      st   = 2'($urandom_range(0, 2));
      w    = (kind <= 3) || (kind == 9);
      r    = (kind >= 4);
      if (kind <= 3 && $urandom_range(0, 7) == 0) st = 2'b11;
      g  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
      rv = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
      access(w, r, st, lt, $urandom, $urandom, $urandom, g, rv, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    repeat (4) idle_cycle();
    chk("res_q_drained", res_q.size(), 32'd0);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("stall_q_drained", stall_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
